oled_power_sequencer: RTL
=========================

# oled_power_sequencer

Power-up/power-down controller and SPI byte-channel arbiter for the SSD1306 OLED in the frequency-counter design. It drives the panel rail enables and reset, streams the fixed init command list into the SPI byte serializer, then hands the serializer to the display-data writer. On request it runs the reverse shutdown sequence.

## Interface
- `T_VDD`, 100: cycles waited after VDD on, before the first command.
- `T_RST`, 100: cycles reset is held low; also the post-reset wait.
- `T_VBAT`, 10000: cycles waited after a VBAT change. All delay parameters are 1..2^24-1; the wait counter is 24 bits.
- `clk` in 1: the only clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle power-up request.
- `stop` in 1: single-cycle power-down request.
- `spi_valid` out 1, `spi_byte` out 8, `spi_dc` out 1: byte offered to the serializer.
- `spi_ready` in 1: serializer accepts the byte when `spi_valid && spi_ready`.
- `spi_idle` in 1: serializer has no byte in flight.
- `cl_valid` in 1, `cl_byte` in 8, `cl_dc` in 1: client byte request.
- `cl_ready` out 1: client byte accepted when `cl_valid && cl_ready`.
- `oled_rstn_out`, `oled_vbatn_out`, `oled_vcdn_out` out 1 each: panel reset and active-low VBAT/VDD enables.
- `running` out 1: high only in RUN.

## Operation
- Reset values: `oled_rstn_out`=1, `oled_vbatn_out`=1, `oled_vcdn_out`=1, `spi_valid`=0, `spi_byte`=0, `spi_dc`=0, `running`=0. State is OFF and the stop-pending flag is clear.
- Command ROM, with `dc`=0 for every entry: 0:AE 1:8D 2:14 3:D9 4:F1 5:A1 6:C8 7:DA 8:20 9:AF.
- A CMD state presents ROM[i] on `spi_valid`. It holds the byte stable until accepted, then advances i. After its last byte it enters a DRAIN state, which waits for `spi_idle`=1.
- Power-up path:
  - OFF: on `start`, set vcdn low and go to VDD_WAIT.
  - VDD_WAIT: wait T_VDD cycles, then CMD[0].
  - CMD[0] and DRAIN.
  - RST_LOW: rstn low for T_RST cycles.
  - RST_WAIT: rstn high for T_RST cycles.
  - CMD[1..4] and DRAIN.
  - VBAT_ON: set vbatn low.
  - VBAT_WAIT: wait T_VBAT cycles.
  - CMD[5..9] and DRAIN, then RUN.
- RUN is a combinational pass-through:
  - `spi_valid`=`cl_valid`, `spi_byte`=`cl_byte`, `spi_dc`=`cl_dc`, `cl_ready`=`spi_ready`.
  - Outside RUN, `cl_ready`=0.
- `stop` sets stop-pending in any state except OFF.
- RUN exits to shutdown on the first cycle with stop-pending set and `!cl_valid || spi_ready`. A client byte already offered is never withdrawn.
- Shutdown path:
  - SHUT_CMD sends AE, then DRAIN.
  - Set vbatn high, then wait T_VBAT cycles.
  - Set vcdn high and go to OFF, clearing stop-pending.
- A `stop` arriving during power-up does not abort it. The sequence completes, RUN lasts one cycle, then shutdown begins.
- `start` outside OFF is ignored. `stop` in OFF is ignored. If `start` and `stop` arrive in the same OFF cycle, `start` is accepted and `stop` is ignored.
- `rst_n` asserted mid-sequence immediately forces all reset values, including rails off. There is no graceful shutdown.

## Timing
- Panel control outputs and the sequencer's own `spi_*` drive are registered. They change on the clock edge after the deciding condition.
- Wait states last exactly N cycles: the state is entered on edge e and exits on edge e+N.
- `start` sampled on edge k gives `oled_vcdn_out`=0 from edge k onward, and state VDD_WAIT.
- Next-byte latency: after an accept on edge a, the next ROM byte is valid from edge a (back-to-back, 1 byte/cycle when `spi_ready` stays high).
- DRAIN exits on the edge where `spi_idle`=1 is sampled.
- Minimum power-up time with an always-ready, always-idle serializer: T_VDD + 2·T_RST + T_VBAT + 10 byte cycles + 3 drain cycles + 1 (VBAT_ON).

## Test plan
1. Params T_VDD=4, T_RST=3, T_VBAT=20; serializer always ready/idle; pulse `start` -> vcdn low, AE, rstn low exactly 3 cycles, 8D 14 D9 F1, vbatn low, 20-cycle gap, A1 C8 DA 20 AF, all dc=0, then `running`=1.
2. `spi_ready` low for 5 cycles while 0xD9 is offered -> `spi_byte` stays D9 with `spi_valid`=1, and no byte is skipped or duplicated.
3. In RUN, client sends 0x55 dc=1, then 0xAA dc=1 with ready toggling -> both bytes reach the serializer in order, `cl_ready` mirrors `spi_ready`, and bytes are dropped nowhere.
4. `stop` while `cl_valid`=1 and `spi_ready`=0 -> RUN held until accept, then AE dc=0, vbatn high, 20 cycles later vcdn high, `running`=0.
5. `stop` during VBAT_WAIT -> full init completes, one RUN cycle, then shutdown. A second `start` in the same window is ignored.
6. `rst_n` low during CMD[3] -> same cycle: `spi_valid`=0, vcdn=vbatn=rstn=1. After release, a new `start` restarts from ROM[0].

Source files
------------

// File: rtl/oled_power_sequencer.sv
// SSD1306 power sequencer: steps the panel rails, reset and init command list, then
// hands the SPI byte channel to the display-data client until a stop request.
module oled_power_sequencer #(
    parameter int unsigned T_VDD  = 100,
    parameter int unsigned T_RST  = 100,
    parameter int unsigned T_VBAT = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       spi_valid,
    output logic [7:0] spi_byte,
    output logic       spi_dc,
    input  logic       spi_ready,
    input  logic       spi_idle,
    input  logic       cl_valid,
    input  logic [7:0] cl_byte,
    input  logic       cl_dc,
    output logic       cl_ready,
    output logic       oled_rstn_out,
    output logic       oled_vbatn_out,
    output logic       oled_vcdn_out,
    output logic       running
);

    typedef enum logic [3:0] {
        ST_OFF,
        ST_VDD_WAIT,
        ST_CMD,
        ST_DRAIN,
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_VBAT_ON,
        ST_VBAT_WAIT,
        ST_RUN,
        ST_SHUT_CMD,
        ST_SHUT_DRAIN,
        ST_VBAT_OFF_WAIT
    } state_t;

    // Wait states reload with N-1 so they last exactly N cycles.
    localparam logic [23:0] VDD_LOAD  = 24'(T_VDD - 1);
    localparam logic [23:0] RST_LOAD  = 24'(T_RST - 1);
    localparam logic [23:0] VBAT_LOAD = 24'(T_VBAT - 1);

    localparam logic [3:0] IDX_SEG0_LAST = 4'd0;
    localparam logic [3:0] IDX_SEG1_LAST = 4'd4;
    localparam logic [3:0] IDX_SEG2_LAST = 4'd9;

    localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg, idx_next;
    logic [23:0] cnt_reg, cnt_next;
    logic        stop_pend_reg, stop_pend_next;
    logic        seq_valid_reg, seq_valid_next;
    logic [7:0]  seq_byte_reg, seq_byte_next;
    logic        rstn_reg, rstn_next;
    logic        vbatn_reg, vbatn_next;
    logic        vcdn_reg, vcdn_next;

    logic        in_run;
    logic        seq_accept;
    logic        cnt_done;
    logic        seg_last;

    function automatic logic [7:0] rom_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'hAE;
            4'd1:    b = 8'h8D;
            4'd2:    b = 8'h14;
            4'd3:    b = 8'hD9;
            4'd4:    b = 8'hF1;
            4'd5:    b = 8'hA1;
            4'd6:    b = 8'hC8;
            4'd7:    b = 8'hDA;
            4'd8:    b = 8'h20;
            4'd9:    b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign in_run     = (state_reg == ST_RUN);
    assign seq_accept = seq_valid_reg && spi_ready;
    assign cnt_done   = (cnt_reg == 24'd0);
    assign seg_last   = (idx_reg == IDX_SEG0_LAST) || (idx_reg == IDX_SEG1_LAST) ||
                        (idx_reg == IDX_SEG2_LAST);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_done ? cnt_reg : cnt_reg - 24'd1;
        stop_pend_next = stop_pend_reg;
        seq_valid_next = 1'b0;
        seq_byte_next  = 8'h00;
        rstn_next      = 1'b1;
        vbatn_next     = vbatn_reg;
        vcdn_next      = 1'b0;

        case (state_reg)
            ST_OFF: begin
                if (start) begin
                    state_next = ST_VDD_WAIT;
                    idx_next   = 4'd0;
                end
            end
            ST_VDD_WAIT: begin
                if (cnt_done) state_next = ST_CMD;
            end
            ST_CMD: begin
                if (seq_accept) begin
                    if (seg_last) state_next = ST_DRAIN;
                    else          idx_next   = idx_reg + 4'd1;
                end
            end
            ST_DRAIN: begin
                // The index of the segment just sent selects the step that follows.
                if (spi_idle) begin
                    case (idx_reg)
                        IDX_SEG0_LAST: state_next = ST_RST_LOW;
                        IDX_SEG1_LAST: state_next = ST_VBAT_ON;
                        default:       state_next = ST_RUN;
                    endcase
                end
            end
            ST_RST_LOW: begin
                if (cnt_done) state_next = ST_RST_WAIT;
            end
            ST_RST_WAIT: begin
                if (cnt_done) begin
                    state_next = ST_CMD;
                    idx_next   = idx_reg + 4'd1;
                end
            end
            ST_VBAT_ON: begin
                state_next = ST_VBAT_WAIT;
            end
            ST_VBAT_WAIT: begin
                if (cnt_done) begin
                    state_next = ST_CMD;
                    idx_next   = idx_reg + 4'd1;
                end
            end
            ST_RUN: begin
                // Leave only when no client byte is left hanging mid-handshake.
                if (stop_pend_reg && (!cl_valid || spi_ready)) state_next = ST_SHUT_CMD;
            end
            ST_SHUT_CMD: begin
                if (seq_accept) state_next = ST_SHUT_DRAIN;
            end
            ST_SHUT_DRAIN: begin
                if (spi_idle) state_next = ST_VBAT_OFF_WAIT;
            end
            ST_VBAT_OFF_WAIT: begin
                if (cnt_done) state_next = ST_OFF;
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase

        if (state_next != state_reg) begin
            case (state_next)
                ST_VDD_WAIT:                   cnt_next = VDD_LOAD;
                ST_RST_LOW, ST_RST_WAIT:       cnt_next = RST_LOAD;
                ST_VBAT_WAIT, ST_VBAT_OFF_WAIT: cnt_next = VBAT_LOAD;
                default:                       cnt_next = cnt_reg;
            endcase
        end

        if (stop && (state_reg != ST_OFF)) stop_pend_next = 1'b1;
        if (state_next == ST_OFF)          stop_pend_next = 1'b0;

        // Outputs are registered from the next state so they track it edge-for-edge.
        if (state_next == ST_CMD) begin
            seq_valid_next = 1'b1;
            seq_byte_next  = rom_byte(idx_next);
        end else if (state_next == ST_SHUT_CMD) begin
            seq_valid_next = 1'b1;
            seq_byte_next  = CMD_DISPLAY_OFF;
        end

        if (state_next == ST_RST_LOW)       rstn_next  = 1'b0;
        if (state_next == ST_VBAT_ON)       vbatn_next = 1'b0;
        if (state_next == ST_VBAT_OFF_WAIT) vbatn_next = 1'b1;
        if (state_next == ST_OFF) begin
            vbatn_next = 1'b1;
            vcdn_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_OFF;
            idx_reg       <= 4'd0;
            cnt_reg       <= 24'd0;
            stop_pend_reg <= 1'b0;
            seq_valid_reg <= 1'b0;
            seq_byte_reg  <= 8'h00;
            rstn_reg      <= 1'b1;
            vbatn_reg     <= 1'b1;
            vcdn_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            stop_pend_reg <= stop_pend_next;
            seq_valid_reg <= seq_valid_next;
            seq_byte_reg  <= seq_byte_next;
            rstn_reg      <= rstn_next;
            vbatn_reg     <= vbatn_next;
            vcdn_reg      <= vcdn_next;
        end
    end

    // In RUN the client owns the channel combinationally; otherwise the sequencer does.
    assign spi_valid      = in_run ? cl_valid : seq_valid_reg;
    assign spi_byte       = in_run ? cl_byte  : seq_byte_reg;
    assign spi_dc         = in_run ? cl_dc    : 1'b0;
    assign cl_ready       = in_run ? spi_ready : 1'b0;
    assign running        = in_run;
    assign oled_rstn_out  = rstn_reg;
    assign oled_vbatn_out = vbatn_reg;
    assign oled_vcdn_out  = vcdn_reg;

endmodule
